// File: rtl/dircc_node_irq_event_fifo_pkg.sv
// Shared definitions for the node interrupt event collector: register map,
// bit positions and the queued event record.
package dircc_node_irq_pkg;

  localparam int TS_W  = 32;
  localparam int SRC_W = 4;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EVT_SRC  = 3'd3;
  localparam logic [2:0] ADDR_EVT_TS_L = 3'd4;
  localparam logic [2:0] ADDR_EVT_TS_H = 3'd5;
  localparam logic [2:0] ADDR_POP      = 3'd6;
  localparam logic [2:0] ADDR_LOST     = 3'd7;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_W   = 7;
  localparam int CTL_EN     = 0;
  localparam int CTL_FLUSH  = 1;
  localparam int EVT_VALID  = 15;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [TS_W-1:0]  ts;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/dircc_node_irq_event_fifo_if.sv
// 16-bit Avalon-MM register port of the interrupt event collector.
interface dircc_node_irq_event_fifo_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/dircc_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle. Flush overrides push and pop.
module dircc_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dircc_node_irq_event_fifo.sv
// Interrupt event collector: rising-edge capture of level irq lines,
// per-source pending slot with timestamp, lowest-index drain into an
// event FIFO, Avalon-MM register access and a single irq to the processor.
// TS_INIT only exists so a bench can start the counter near wrap.
module dircc_node_irq_event_fifo
  import dircc_node_irq_pkg::*;
#(
  parameter int              NUM_SRC    = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [TS_W-1:0] TS_INIT    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  src_irq,
  dircc_node_irq_event_fifo_if.slave bus,
  output logic                irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TS_W-1:0]    ts_cnt;
  logic [NUM_SRC-1:0] src_d, mask, pend, sel_oh, edge_v, pend_base, drop_v;
  logic [TS_W-1:0]    pend_ts [NUM_SRC];
  logic               irq_en, ovf;
  logic [15:0]        lost, lost_base, lost_nxt, rd_nxt;
  logic [16:0]        lost_sum;
  logic [4:0]         n_drop;
  logic               wr, flush, pop_req, sel_vld, push_ok;
  evt_t               push_evt, head_evt;
  logic [EVT_W-1:0]   head_raw;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               unused_wd;

  assign unused_wd = ^bus.writedata;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign flush   = wr && (bus.address == ADDR_CONTROL) && bus.writedata[CTL_FLUSH];
  assign pop_req = wr && (bus.address == ADDR_POP);
  assign edge_v  = src_irq & ~src_d & mask;

  // lowest-index pending source wins the single push slot
  always_comb begin
    sel_vld  = 1'b0;
    sel_oh   = '0;
    push_evt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend[i] && !sel_vld) begin
        sel_vld      = 1'b1;
        sel_oh[i]    = 1'b1;
        push_evt.src = SRC_W'(i);
        push_evt.ts  = pend_ts[i];
      end
    end
  end

  // a pop frees the slot a full FIFO needs, so both can happen together
  assign push_ok   = sel_vld & (~fifo_full | (pop_req & ~fifo_empty));
  // pending state after drain/flush; this cycle's edges are judged against it
  assign pend_base = flush ? '0 : (pend & ~(sel_oh & {NUM_SRC{push_ok}}));
  assign drop_v    = edge_v & pend_base;

  assign lost_base = (wr && (bus.address == ADDR_LOST)) ? '0 : lost;
  assign n_drop    = 5'($countones(drop_v));
  assign lost_sum  = {1'b0, lost_base} + {12'd0, n_drop};
  assign lost_nxt  = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];

  assign irq = irq_en & ~fifo_empty;

  dircc_sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop_req),
    .flush (flush),
    .wdata (push_evt),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign head_evt = evt_t'(head_raw);

  // free-running timestamp and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= TS_INIT;
      src_d  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      src_d  <= src_irq;
    end
  end

  // pending slots, captured timestamps, drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      ovf  <= 1'b0;
      lost <= '0;
      for (int i = 0; i < NUM_SRC; i++) pend_ts[i] <= '0;
    end else begin
      pend <= pend_base | edge_v;
      for (int i = 0; i < NUM_SRC; i++)
        if (edge_v[i] && !pend_base[i]) pend_ts[i] <= ts_cnt;
      lost <= lost_nxt;
      if (|drop_v)                                ovf <= 1'b1;
      else if (wr && (bus.address == ADDR_STATUS)) ovf <= 1'b0;
    end
  end

  // control and mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      mask   <= '1;
    end else begin
      if (wr && (bus.address == ADDR_CONTROL)) irq_en <= bus.writedata[CTL_EN];
      if (wr && (bus.address == ADDR_MASK))    mask   <= bus.writedata[NUM_SRC-1:0];
    end
  end

  // read mux, registered every cycle regardless of chipselect
  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      ADDR_STATUS: begin
        rd_nxt[ST_NEMPTY]                = ~fifo_empty;
        rd_nxt[ST_OVF]                   = ovf;
        rd_nxt[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
      end
      ADDR_CONTROL: rd_nxt[CTL_EN] = irq_en;
      ADDR_MASK:    rd_nxt[NUM_SRC-1:0] = mask;
      ADDR_EVT_SRC: if (!fifo_empty) begin
        rd_nxt[EVT_VALID]   = 1'b1;
        rd_nxt[SRC_W-1:0]   = head_evt.src;
      end
      ADDR_EVT_TS_L: if (!fifo_empty) rd_nxt = head_evt.ts[15:0];
      ADDR_EVT_TS_H: if (!fifo_empty) rd_nxt = head_evt.ts[31:16];
      ADDR_LOST:    rd_nxt = lost;
      default:      rd_nxt = '0;
    endcase
  end

  // registered read data
  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_nxt;
  end

endmodule

// File: tb/tb_dircc_node_irq_event_fifo.sv
// Bench for the interrupt event collector: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
// A second instance starts its timestamp just below wrap.
module tb_dircc_node_irq_event_fifo;
  localparam int          NS     = 4;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] W_INIT = 32'hFFFF_FFFA;

  logic          clk = 1'b0;
  logic          rst, rst2, irq, irq2;
  logic [NS-1:0] src, src2;
  int            n_tests = 0, n_fail = 0;
  logic [31:0]   t, t2;
  logic [15:0]   d;

  dircc_node_irq_event_fifo_if bus();
  dircc_node_irq_event_fifo_if bus2();

  dircc_node_irq_event_fifo #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .src_irq(src), .bus(bus), .irq(irq));

  dircc_node_irq_event_fifo #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .TS_INIT(W_INIT)) dut_wrap (
    .clk(clk), .reset(rst2), .src_irq(src2), .bus(bus2), .irq(irq2));

  always #5 clk = ~clk;

  // reference model state
  typedef struct { logic [3:0] src; logic [31:0] ts; } ev_t;
  ev_t           m_q[$];
  logic [31:0]   m_ts;
  logic [31:0]   m_pts [NS];
  logic [NS-1:0] m_srcd, m_mask, m_pend;
  logic          m_en, m_ovf;
  logic [15:0]   m_lost, m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic          wr, fl;
    logic [NS-1:0] ed, base;
    int            first, drops;
    if (rst) begin
      m_q.delete(); m_ts = 0; m_srcd = '0; m_mask = '1; m_pend = '0;
      m_en = 0; m_ovf = 0; m_lost = 0; m_rd = 0;
      return;
    end
    m_rd = 16'h0;
    case (bus.address)
      3'd0: m_rd = {7'd0, 7'(m_q.size()), m_ovf, m_q.size() != 0};
      3'd1: m_rd = {15'd0, m_en};
      3'd2: m_rd = 16'(m_mask);
      3'd3: if (m_q.size() != 0) m_rd = {1'b1, 11'd0, m_q[0].src};
      3'd4: if (m_q.size() != 0) m_rd = m_q[0].ts[15:0];
      3'd5: if (m_q.size() != 0) m_rd = m_q[0].ts[31:16];
      3'd7: m_rd = m_lost;
      default: ;
    endcase
    wr    = bus.chipselect && !bus.write_n;
    fl    = wr && bus.address == 3'd1 && bus.writedata[1];
    ed    = src & ~m_srcd & m_mask;
    base  = m_pend;
    drops = 0;
    if (fl) begin
      m_q.delete();
      base = '0;
    end else begin
      if (wr && bus.address == 3'd6 && m_q.size() > 0) void'(m_q.pop_front());
      first = -1;
      for (int i = NS-1; i >= 0; i--) if (base[i]) first = i;
      if (first >= 0 && m_q.size() < DEPTH) begin
        m_q.push_back('{4'(first), m_pts[first]});
        base[first] = 1'b0;
      end
    end
    for (int i = 0; i < NS; i++) if (ed[i]) begin
      if (base[i]) drops++;
      else begin base[i] = 1'b1; m_pts[i] = m_ts; end
    end
    if (wr && bus.address == 3'd7) m_lost = 0;
    for (int k = 0; k < drops; k++) if (m_lost != 16'hFFFF) m_lost++;
    if (drops > 0) m_ovf = 1;
    else if (wr && bus.address == 3'd0) m_ovf = 0;
    if (wr && bus.address == 3'd1) m_en = bus.writedata[0];
    if (wr && bus.address == 3'd2) m_mask = bus.writedata[NS-1:0];
    m_pend = base;
    m_srcd = src;
    m_ts++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", 32'(irq), 32'(m_en && m_q.size() != 0));
    chk("readdata", 32'(bus.readdata), 32'(m_rd));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] v);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = v;
    step();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] a, input logic [15:0] e);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    step();
    chk(tag, 32'(bus.readdata), 32'(e));
    bus.chipselect = 1'b0;
  endtask

  task automatic pulse(input int b);
    src[b] = 1'b1; step();
    src[b] = 1'b0; step();
  endtask

  task automatic cyc2();
    @(posedge clk); #1; t2++;
  endtask

  task automatic expect_reg2(input string tag, input logic [2:0] a, input logic [15:0] e);
    bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1;
    cyc2();
    chk(tag, 32'(bus2.readdata), 32'(e));
    bus2.chipselect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; src = '0; src2 = '0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    repeat (3) step();
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rd", 32'(bus.readdata), 32'd0);
    rst = 1'b0;

    // single edge at timestamp 100
    wr_reg(3'd1, 16'h0001);
    for (int k = 0; k < 200 && m_ts != 32'd100; k++) step();
    src[0] = 1'b1; step();
    chk("edge_irq_n1", 32'(irq), 32'd0);
    step();
    chk("edge_irq_n2", 32'(irq), 32'd1);
    expect_reg("single_src", 3'd3, 16'h8000);
    expect_reg("single_ts_l", 3'd4, 16'd100);
    expect_reg("single_ts_h", 3'd5, 16'd0);
    wr_reg(3'd6, 16'h0);
    chk("pop_irq", 32'(irq), 32'd0);
    expect_reg("pop_status", 3'd0, 16'h0000);
    src = '0; step();

    // simultaneous edges on sources 2 and 1
    t = m_ts;
    src = 4'b0110;
    repeat (3) step();
    expect_reg("two_status", 3'd0, 16'h0009);
    expect_reg("two_src_a", 3'd3, 16'h8001);
    expect_reg("two_ts_a", 3'd4, t[15:0]);
    wr_reg(3'd6, 16'h0);
    expect_reg("two_src_b", 3'd3, 16'h8002);
    expect_reg("two_ts_b", 3'd4, t[15:0]);
    wr_reg(3'd6, 16'h0);
    src = '0; step();

    // overflow: 8 queued, 1 held, 1 dropped
    wr_reg(3'd2, 16'h0001);
    repeat (10) pulse(0);
    step();
    expect_reg("ovf_status", 3'd0, 16'h0023);
    expect_reg("ovf_lost", 3'd7, 16'd1);
    wr_reg(3'd0, 16'h0);
    expect_reg("ovf_clear", 3'd0, 16'h0021);
    expect_reg("lost_keep", 3'd7, 16'd1);
    wr_reg(3'd7, 16'h0);
    expect_reg("lost_clear", 3'd7, 16'd0);

    // full FIFO with pending src 0 and src 3: pop and push together
    wr_reg(3'd2, 16'h000F);
    src[3] = 1'b1; step(); step();
    wr_reg(3'd6, 16'h0);
    expect_reg("full_pop_status", 3'd0, 16'h0021);
    repeat (7) wr_reg(3'd6, 16'h0);
    expect_reg("held_src0", 3'd3, 16'h8000);
    wr_reg(3'd6, 16'h0);
    expect_reg("tail_src3", 3'd3, 16'h8003);
    expect_reg("tail_status", 3'd0, 16'h0005);
    src = '0; step();

    // flush
    pulse(1); pulse(2); pulse(0);
    wr_reg(3'd1, 16'h0003);
    chk("flush_irq", 32'(irq), 32'd0);
    expect_reg("flush_status", 3'd0, 16'h0000);
    expect_reg("flush_ctrl", 3'd1, 16'h0001);

    // masked source
    wr_reg(3'd2, 16'h0000);
    pulse(0); step();
    expect_reg("mask_status", 3'd0, 16'h0000);
    wr_reg(3'd2, 16'h000F);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      src = src ^ NS'($urandom & $urandom & $urandom);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 2) != 0);
      bus.address    = 3'($urandom);
      if (!bus.write_n && $urandom_range(0, 2) == 0) bus.address = 3'd6;
      bus.writedata  = 16'($urandom);
      if (bus.address == 3'd1 && $urandom_range(0, 7) != 0) bus.writedata[1] = 1'b0;
      step();
    end
    rst = 1'b0; src = '0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    step();

    // reset while full
    wr_reg(3'd1, 16'h0003);
    wr_reg(3'd2, 16'h0001);
    repeat (10) pulse(0);
    expect_reg("pre_rst_status", 3'd0, 16'h0023);
    rst = 1'b1; step();
    chk("rst_full_irq", 32'(irq), 32'd0);
    chk("rst_full_rd", 32'(bus.readdata), 32'd0);
    rst = 1'b0;
    expect_reg("rst_mask", 3'd2, 16'h000F);
    expect_reg("rst_status", 3'd0, 16'h0000);

    // timestamp wrap on the preloaded instance
    rst2 = 1'b0; t2 = W_INIT;
    for (int k = 0; k < 16 && t2 != 32'hFFFF_FFFF; k++) cyc2();
    src2[0] = 1'b1; cyc2();
    src2[0] = 1'b0; cyc2();
    src2[0] = 1'b1; cyc2();
    src2[0] = 1'b0; repeat (3) cyc2();
    expect_reg2("wrap_status", 3'd0, 16'h0009);
    expect_reg2("wrap_src", 3'd3, 16'h8000);
    expect_reg2("wrap_ts_l_a", 3'd4, 16'hFFFF);
    expect_reg2("wrap_ts_h_a", 3'd5, 16'hFFFF);
    bus2.address = 3'd6; bus2.chipselect = 1'b1; bus2.write_n = 1'b0; cyc2();
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    expect_reg2("wrap_ts_l_b", 3'd4, 16'h0001);
    expect_reg2("wrap_ts_h_b", 3'd5, 16'h0000);
    chk("wrap_irq", 32'(irq2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
